// File: rtl/instr_fetch_unit_if.sv
// Memory read bus plus the instruction handshake between the fetch unit (master)
// and the memory / decoder / control side (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rd_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [1:0]            len_i;
  logic [DATA_WIDTH-1:0] opcode_o;
  logic [DATA_WIDTH-1:0] operand_lo_o;
  logic [DATA_WIDTH-1:0] operand_hi_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_valid_o;
  logic                  instr_ready_i;

  modport master (
    output mem_addr_o, mem_rd_o, opcode_o, operand_lo_o, operand_hi_o,
           instr_pc_o, instr_valid_o,
    input  mem_rdata_i, len_i, instr_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_o, opcode_o, operand_lo_o, operand_hi_o,
           instr_pc_o, instr_valid_o,
    output mem_rdata_i, len_i, instr_ready_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetcher: reads a 1..3 byte instruction through a
// one-cycle-latency memory port and presents it with a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus_if,
  input  logic                  pc_load_i,
  input  logic [ADDR_WIDTH-1:0] pc_load_val_i,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  typedef enum logic [2:0] {
    FETCH_OP, WAIT_OP, DECODE, FETCH_OPR, WAIT_OPR, VALID, HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instrPc_q, instrPc_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] operandLo_q, operandLo_d;
  logic [DATA_WIDTH-1:0] operandHi_q, operandHi_d;
  logic [1:0]            remCount_q, remCount_d;
  logic                  oprIdx_q, oprIdx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_OP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      instrPc_q   <= '0;
      opcode_q    <= '0;
      operandLo_q <= '0;
      operandHi_q <= '0;
      remCount_q  <= '0;
      oprIdx_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instrPc_q   <= instrPc_d;
      opcode_q    <= opcode_d;
      operandLo_q <= operandLo_d;
      operandHi_q <= operandHi_d;
      remCount_q  <= remCount_d;
      oprIdx_q    <= oprIdx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instrPc_d   = instrPc_q;
    opcode_d    = opcode_q;
    operandLo_d = operandLo_q;
    operandHi_d = operandHi_q;
    remCount_d  = remCount_q;
    oprIdx_d    = oprIdx_q;

    case (state_q)
      FETCH_OP: state_d = WAIT_OP;
      WAIT_OP: begin
        opcode_d    = bus_if.mem_rdata_i;
        instrPc_d   = pc_q;
        operandLo_d = '0;
        operandHi_d = '0;
        pc_d        = pc_q + ADDR_WIDTH'(1);
        state_d     = DECODE;
      end
      DECODE: begin
        if (bus_if.len_i <= 2'd1) begin
          state_d = VALID;
        end else begin
          remCount_d = bus_if.len_i - 2'd1;
          oprIdx_d   = 1'b0;
          state_d    = FETCH_OPR;
        end
      end
      FETCH_OPR: state_d = WAIT_OPR;
      WAIT_OPR: begin
        if (!oprIdx_q) begin
          operandLo_d = bus_if.mem_rdata_i;
        end else begin
          operandHi_d = bus_if.mem_rdata_i;
        end
        oprIdx_d   = 1'b1;
        pc_d       = pc_q + ADDR_WIDTH'(1);
        remCount_d = remCount_q - 2'd1;
        state_d    = (remCount_q == 2'd1) ? VALID : FETCH_OPR;
      end
      VALID: begin
        if (bus_if.instr_ready_i) begin
          state_d = halt_i ? HALTED : FETCH_OP;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH_OP;
    endcase

    // A jump overrides everything, including a handshake, halt and any read in flight.
    if (pc_load_i) begin
      pc_d    = pc_load_val_i;
      state_d = FETCH_OP;
    end
  end

  // The read strobe is gated by reset because reset parks the FSM in FETCH_OP.
  always_comb begin
    bus_if.mem_rd_o      = 1'b0;
    bus_if.instr_valid_o = 1'b0;
    case (state_q)
      FETCH_OP, FETCH_OPR: bus_if.mem_rd_o      = reset;
      VALID:               bus_if.instr_valid_o = 1'b1;
      default:             ;
    endcase
  end

  assign bus_if.mem_addr_o   = pc_q;
  assign bus_if.opcode_o     = opcode_q;
  assign bus_if.operand_lo_o = operandLo_q;
  assign bus_if.operand_hi_o = operandHi_q;
  assign bus_if.instr_pc_o   = instrPc_q;
  assign pc_o                = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory and decoder models, an instruction-level
// reference model feeding a scoreboard queue, and an independent monitor.
module tb_instr_fetch_unit;

  typedef struct {
    logic [7:0]  opcode;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] instrPc;
    logic [15:0] pcAfter;
    int          latency;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pcLoad;
  logic [15:0] pcLoadVal;
  logic        halt;
  logic [15:0] pcOut;

  logic [7:0]  mem [0:65535];
  logic [1:0]  lenTable [0:255];
  exp_t        expQ [$];
  exp_t        curExp;

  int testsRun;
  int testsFailed;
  int acceptedCount;
  int cycle;
  int fetchCycle;
  bit awaitOpcode;
  bit prevValid;
  bit halted;
  logic [15:0] haltPc;

  instr_fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifc ();

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .bus_if       (ifc),
    .pc_load_i    (pcLoad),
    .pc_load_val_i(pcLoadVal),
    .halt_i       (halt),
    .pc_o         (pcOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Memory answers one cycle after the strobe; idle cycles return junk.
  always @(posedge clk) begin
    if (ifc.mem_rd_o) ifc.mem_rdata_i <= mem[ifc.mem_addr_o];
    else              ifc.mem_rdata_i <= 8'($urandom);
  end

  assign ifc.len_i = lenTable[ifc.opcode_o];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Instruction-level reference: walk memory by decoded length.
  task automatic predict(input logic [15:0] startPc, input int n, output logic [15:0] endPc);
    logic [15:0] p;
    int          len;
    exp_t        e;
    p = startPc;
    for (int k = 0; k < n; k++) begin
      e.instrPc = p;
      e.opcode  = mem[p];
      len       = (lenTable[e.opcode] == 2'd0) ? 1 : int'(lenTable[e.opcode]);
      e.lo      = (len >= 2) ? mem[16'(p + 16'd1)] : 8'h00;
      e.hi      = (len == 3) ? mem[16'(p + 16'd2)] : 8'h00;
      e.pcAfter = 16'(p + 16'(len));
      e.latency = 2 * len + 1;
      expQ.push_back(e);
      p = e.pcAfter;
    end
    endPc = p;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prevValid   = 1'b0;
      awaitOpcode = 1'b1;
      halted      = 1'b0;
    end else begin
      if (halted) begin
        checkOutput("halted_no_read", 32'(ifc.mem_rd_o), 32'd0);
        checkOutput("halted_valid_low", 32'(ifc.instr_valid_o), 32'd0);
        checkOutput("halted_pc", 32'(pcOut), 32'(haltPc));
      end
      if (ifc.mem_rd_o && awaitOpcode && !pcLoad) begin
        fetchCycle  = cycle;
        awaitOpcode = 1'b0;
        if (expQ.size() > 0) checkOutput("fetch_addr", 32'(ifc.mem_addr_o), 32'(expQ[0].instrPc));
      end
      if (ifc.instr_valid_o && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 32'(ifc.instr_pc_o), 32'hFFFF_FFFF);
        end else begin
          curExp = expQ.pop_front();
          checkOutput("opcode", 32'(ifc.opcode_o), 32'(curExp.opcode));
          checkOutput("operand_lo", 32'(ifc.operand_lo_o), 32'(curExp.lo));
          checkOutput("operand_hi", 32'(ifc.operand_hi_o), 32'(curExp.hi));
          checkOutput("instr_pc", 32'(ifc.instr_pc_o), 32'(curExp.instrPc));
          checkOutput("pc_after", 32'(pcOut), 32'(curExp.pcAfter));
          checkOutput("latency", 32'(cycle - fetchCycle), 32'(curExp.latency));
        end
      end else if (ifc.instr_valid_o && prevValid) begin
        checkOutput("stall_opcode", 32'(ifc.opcode_o), 32'(curExp.opcode));
        checkOutput("stall_operands", {16'h0, ifc.operand_hi_o, ifc.operand_lo_o}, {16'h0, curExp.hi, curExp.lo});
        checkOutput("stall_pc", {ifc.instr_pc_o, pcOut}, {curExp.instrPc, curExp.pcAfter});
        checkOutput("stall_no_read", 32'(ifc.mem_rd_o), 32'd0);
      end
      if (pcLoad) begin
        awaitOpcode = 1'b1;
        halted      = 1'b0;
      end else if (ifc.instr_valid_o && ifc.instr_ready_i) begin
        acceptedCount++;
        awaitOpcode = 1'b1;
        if (halt) begin
          halted = 1'b1;
          haltPc = pcOut;
        end
      end
      prevValid = ifc.instr_valid_o;
    end
  end

  // startMode: 0 = via reset, 1 = via jump, 2 = jump already driven by caller.
  // readyMode: 0 = always ready, 1 = random, 2 = hold off five VALID cycles.
  task automatic applyStimulus(input logic [15:0] startPc, input int n, input int startMode, input int readyMode);
    logic [15:0] endPc;
    int          base;
    int          vcnt;
    bit          done;
    halt = 1'b0;
    if (startMode == 0) begin
      @(posedge clk); #1;
      reset = 1'b0;
      pcLoad = 1'b0;
      ifc.instr_ready_i = 1'b0;
      #1;
      checkOutput("rst_pc", 32'(pcOut), 32'hF000);
      checkOutput("rst_opcode", 32'(ifc.opcode_o), 32'd0);
      checkOutput("rst_operand_lo", 32'(ifc.operand_lo_o), 32'd0);
      checkOutput("rst_operand_hi", 32'(ifc.operand_hi_o), 32'd0);
      checkOutput("rst_instr_pc", 32'(ifc.instr_pc_o), 32'd0);
      checkOutput("rst_valid", 32'(ifc.instr_valid_o), 32'd0);
      checkOutput("rst_mem_rd", 32'(ifc.mem_rd_o), 32'd0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
    end
    predict(startPc, n, endPc);
    base = acceptedCount;
    if (startMode == 0) begin
      reset = 1'b1;
    end else if (startMode == 1) begin
      pcLoad    = 1'b1;
      pcLoadVal = startPc;
    end
    vcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 60 * n + 40 && !done; c++) begin
      @(posedge clk); #1;
      pcLoad = 1'b0;
      if (acceptedCount - base >= n) begin
        done = 1'b1;
      end else begin
        halt = (acceptedCount - base == n - 1);
        vcnt = ifc.instr_valid_o ? vcnt + 1 : 0;
        case (readyMode)
          0:       ifc.instr_ready_i = 1'b1;
          1:       ifc.instr_ready_i = ($urandom_range(0, 2) != 0);
          default: ifc.instr_ready_i = (vcnt > 5);
        endcase
      end
    end
    if (!done) checkOutput("segment_timeout", 32'(acceptedCount - base), 32'(n));
    halt = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      ifc.instr_ready_i = 1'($urandom_range(0, 1));
    end
    checkOutput("halt_pc_hold", 32'(pcOut), 32'(endPc));
    ifc.instr_ready_i = 1'b0;
  endtask

  // Jump to badPc, then jump away while its first operand read is in flight.
  task automatic abortDuringOperand(input logic [15:0] badPc, input logic [15:0] target, input int n);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    halt      = 1'b0;
    pcLoad    = 1'b1;
    pcLoadVal = badPc;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      pcLoad = 1'b0;
      if (ifc.mem_rd_o && ifc.mem_addr_o == 16'(badPc + 16'd1)) seen = 1'b1;
    end
    checkOutput("abort_reach_operand", 32'(seen), 32'd1);
    @(posedge clk); #1;
    pcLoad    = 1'b1;
    pcLoadVal = target;
    applyStimulus(target, n, 2, 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0;
    testsFailed = 0;
    acceptedCount = 0;
    cycle = 0;
    fetchCycle = 0;
    reset = 1'b0;
    pcLoad = 1'b0;
    pcLoadVal = 16'h0;
    halt = 1'b0;
    ifc.instr_ready_i = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) lenTable[a] = 2'($urandom);

    mem[16'hF000] = 8'h12;
    lenTable[8'h12] = 2'd1;
    applyStimulus(16'hF000, 1, 0, 0);

    mem[16'hF000] = 8'h30; mem[16'hF001] = 8'h01;
    mem[16'hF002] = 8'h40; mem[16'hF003] = 8'hFE; mem[16'hF004] = 8'hAB;
    lenTable[8'h30] = 2'd2;
    lenTable[8'h40] = 2'd3;
    applyStimulus(16'hF000, 2, 0, 2);

    mem[16'h2000] = 8'h40;
    abortDuringOperand(16'h2000, 16'h0100, 4);

    mem[16'hFFFF] = 8'h30;
    mem[16'h0000] = 8'h5A;
    applyStimulus(16'hFFFF, 1, 1, 1);

    for (int s = 0; s < 6; s++) applyStimulus(16'($urandom), $urandom_range(2, 6), 1, 1);

    mem[16'h3000] = 8'h40;
    @(posedge clk); #1;
    pcLoad    = 1'b1;
    pcLoadVal = 16'h3000;
    repeat (2) begin
      @(posedge clk); #1;
      pcLoad = 1'b0;
    end
    applyStimulus(16'hF000, 3, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
